window_strip_feeder: RTL and testbench
======================================

WINDOW_STRIP_FEEDER -- requirements
Module: window_strip_feeder

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 64, image columns; legal values are 2 or more.
REQ-003 SHALL have parameter IMG_HEIGHT, default 64, image rows; legal values are 2 or more.
REQ-004 SHALL have parameter ADDR_WIDTH, default 12; it must satisfy 2^ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT.
REQ-005 SHALL have ports, in this order:
- clk (in, 1): clock, rising edge.
- reset (in, 1): synchronous, active-high.
- start (in, 1): single-cycle frame start pulse.
- busy (out, 1): high while a frame is in progress.
- done (out, 1): single-cycle pulse when a frame completes.
- rd_en (out, 1): pixel memory read enable.
- rd_addr (out, ADDR_WIDTH): read address, row-major, y*IMG_WIDTH+x.
- rd_data (in, INPUT_WIDTH): read data, valid exactly 1 cycle after rd_en.
- out_left, out_middle, out_right (out, INPUT_WIDTH each): pixels at x-1, x, x+1 of the current row.
- out_valid (out, 1): the row triple is valid.
- out_ready (in, 1): downstream accepts the triple; acceptance = out_valid && out_ready, which is the downstream shift enable.
- out_result_valid (out, 1): after this accept, the downstream filter output holds the result for (out_result_row, out_result_col).
- out_result_row (out, clog2(IMG_HEIGHT)): row of that result.
- out_result_col (out, clog2(IMG_WIDTH)): column of that result.

Function
REQ-006 SHALL process a frame as IMG_WIDTH strips, x = 0 .. IMG_WIDTH-1 in order.
REQ-007 Each strip SHALL be exactly IMG_HEIGHT+5 accepted pushes, indexed p = 0 .. IMG_HEIGHT+4:
- p=0: top zero-pad row.
- p=1..IMG_HEIGHT: image row p-1.
- p=IMG_HEIGHT+1: bottom zero-pad row.
- p=IMG_HEIGHT+2 .. IMG_HEIGHT+4: zero drain rows.
REQ-008 Pad and drain pushes SHALL output all zeros and issue no reads.
REQ-009 Column x-1 < 0 and column x+1 >= IMG_WIDTH SHALL output 0 and issue no read for that position.
REQ-010 The FSM SHALL have states IDLE, RD_L, RD_M, RD_R, WAIT, PRESENT.
REQ-011 FSM transitions:
- IDLE goes to the first push on start.
- For an image-row push: RD_L -> RD_M -> RD_R -> WAIT -> PRESENT, one cycle each.
- For a pad or drain push: go directly to PRESENT.
- PRESENT holds until accept, then goes to the next push, or to IDLE after the final push of the last strip.
REQ-012 In RD_L, RD_M and RD_R, rd_en SHALL be high only for in-range columns.
REQ-013 Read data SHALL be captured 1 cycle after its read is issued; the PRESENT outputs are assembled from these captures.
REQ-014 out_valid SHALL be high only in PRESENT.
REQ-015 While out_valid is high and out_ready is low, the out_* signals SHALL stay stable and no reads SHALL be issued.
REQ-016 The row base address SHALL be kept as a register that increments by IMG_WIDTH per image row, with no multiplier.
REQ-017 rd_addr SHALL equal row_base + x - 1, row_base + x, or row_base + x + 1 for the L, M and R reads respectively.
REQ-018 out_result_valid SHALL be high during PRESENT for p = 5 .. IMG_HEIGHT+4, with out_result_row = p-5 and out_result_col = x; otherwise it is 0.
REQ-019 busy SHALL be high from the cycle after an accepted start until the cycle done is high, inclusive.
REQ-020 done SHALL pulse for exactly 1 cycle, in the cycle after the final accept.
REQ-021 start SHALL be ignored while busy is high.
REQ-022 A start coincident with done SHALL be ignored.

Reset
REQ-023 In every cycle with reset high: state = IDLE, and busy, done, rd_en, out_valid and out_result_valid are all 0.
REQ-024 In every cycle with reset high: out_left, out_middle, out_right, rd_addr, the counters and row_base are all 0.
REQ-025 Reset mid-frame SHALL abandon the frame without asserting done; the next start SHALL begin again at x=0, p=0.

Structure
REQ-026 A shared package SHALL hold:
- the state enumeration;
- TOP_PAD_ROWS=1, BOTTOM_PAD_ROWS=1 and DRAIN_ROWS=3;
- RESULT_LAG=5, the push-to-result offset of the 3x3 filter pipeline.
REQ-027 The block SHALL be a single module with no sub-modules; the strip counter, push counter and row_base live in the top.

Verification
REQ-028 Bench setup: IMG_WIDTH=4, IMG_HEIGHT=3, pixel(y,x) = 16*y + x + 1, out_ready held at 1.
- Strip x=0, p=1: output (0, 1, 2).
- Strip x=1, p=2: output (17, 18, 19).
- Strip x=3, p=3: output (35, 36, 0).
REQ-029 With the REQ-028 setup, a full frame SHALL give:
- exactly 32 accepts;
- done one cycle after the 32nd accept;
- busy low the following cycle;
- reads only for in-range columns, 30 in total.
REQ-030 Drop out_ready low for 5 cycles during PRESENT: out_* stay stable, rd_en stays 0, and the next accept occurs on the first cycle out_ready is high.
REQ-031 Strip x=2: out_result_valid is high only at p=5, 6 and 7, with out_result_row 0, 1 and 2 and out_result_col 2.
REQ-032 Pulse start mid-frame: it is ignored.
REQ-033 Assert reset for 1 cycle at strip 1, p=3:
- all outputs return to reset values and done never pulses;
- a new start restarts at x=0, p=0, giving output (0, 0, 0).

Source files
------------

// File: rtl/window_strip_feeder_pkg.sv
// Shared types and constants for the column-strip window feeder.
// The strip geometry (pad and drain rows) and the 3x3 filter's push-to-result
// lag live here so the feeder and anything downstream agree on them.
package window_strip_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_L,
        RD_M,
        RD_R,
        WAIT,
        PRESENT
    } state_t;

    localparam int TOP_PAD_ROWS    = 1;
    localparam int BOTTOM_PAD_ROWS = 1;
    localparam int DRAIN_ROWS      = 3;
    localparam int RESULT_LAG      = 5;

    // True when push index 'push' carries a real image row rather than a pad or drain row.
    function automatic logic is_image_push(input int push, input int height);
        return (push >= TOP_PAD_ROWS) && (push < TOP_PAD_ROWS + height);
    endfunction

endpackage

// File: rtl/window_strip_feeder.sv
// Streams a frame to a downstream 3x3 filter one column strip at a time.
// Each push presents the left/middle/right pixels of one row around column x;
// pad and drain pushes are all zeros and cost no memory reads. Out-of-image
// neighbours are also zero and are never read. The row base address is
// accumulated instead of multiplied.
module window_strip_feeder #(
    parameter int INPUT_WIDTH = 8,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          rd_en,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    input  logic [INPUT_WIDTH-1:0]        rd_data,
    output logic [INPUT_WIDTH-1:0]        out_left,
    output logic [INPUT_WIDTH-1:0]        out_middle,
    output logic [INPUT_WIDTH-1:0]        out_right,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_result_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_result_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_result_col
);

    import window_strip_feeder_pkg::*;

    localparam int XW     = $clog2(IMG_WIDTH);
    localparam int RW     = $clog2(IMG_HEIGHT);
    localparam int PUSHES = IMG_HEIGHT + TOP_PAD_ROWS + BOTTOM_PAD_ROWS + DRAIN_ROWS;
    localparam int PW     = $clog2(PUSHES);

    localparam logic [PW-1:0]         LAST_P   = PW'(PUSHES - 1);
    localparam logic [XW-1:0]         LAST_X   = XW'(IMG_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = ADDR_WIDTH'(1);

    state_t                  state;
    logic [XW-1:0]           x_cnt;
    logic [PW-1:0]           p_cnt;
    logic [ADDR_WIDTH-1:0]   row_base;

    logic [XW-1:0]           nxt_x;
    logic [PW-1:0]           nxt_p;
    logic [ADDR_WIDTH-1:0]   nxt_base;
    logic [ADDR_WIDTH-1:0]   x_ext;
    logic [ADDR_WIDTH-1:0]   nxt_x_ext;
    logic                    last_push;
    logic                    last_strip;
    logic                    p_is_row;
    logic                    nxt_is_row;
    logic [PW-1:0]           pres_p;
    logic [XW-1:0]           pres_x;
    logic                    res_valid_c;
    logic [RW-1:0]           res_row_c;
    logic [XW-1:0]           res_col_c;

    // Work out where the next push lands and what result tag the next presented push carries.
    always_comb begin
        last_push  = (p_cnt == LAST_P);
        last_strip = (x_cnt == LAST_X);
        p_is_row   = is_image_push(int'(p_cnt), IMG_HEIGHT);
        x_ext      = ADDR_WIDTH'(x_cnt);

        nxt_p    = p_cnt + PW'(1);
        nxt_x    = x_cnt;
        nxt_base = p_is_row ? (row_base + ROW_STEP) : row_base;
        if (last_push) begin
            nxt_p    = '0;
            nxt_x    = last_strip ? '0 : (x_cnt + XW'(1));
            nxt_base = '0;
        end
        nxt_is_row = is_image_push(int'(nxt_p), IMG_HEIGHT);
        nxt_x_ext  = ADDR_WIDTH'(nxt_x);

        pres_p      = (state == WAIT) ? p_cnt : nxt_p;
        pres_x      = (state == WAIT) ? x_cnt : nxt_x;
        res_valid_c = (int'(pres_p) >= RESULT_LAG);
        res_row_c   = res_valid_c ? RW'(int'(pres_p) - RESULT_LAG) : '0;
        res_col_c   = res_valid_c ? pres_x : '0;
    end

    // Frame sequencer: issues the three neighbour reads per image row, assembles the triple and hands it downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            rd_en            <= 1'b0;
            rd_addr          <= '0;
            out_left         <= '0;
            out_middle       <= '0;
            out_right        <= '0;
            out_valid        <= 1'b0;
            out_result_valid <= 1'b0;
            out_result_row   <= '0;
            out_result_col   <= '0;
            x_cnt            <= '0;
            p_cnt            <= '0;
            row_base         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    rd_en            <= 1'b0;
                    out_valid        <= 1'b0;
                    out_result_valid <= 1'b0;
                    if (start && !busy) begin
                        busy           <= 1'b1;
                        x_cnt          <= '0;
                        p_cnt          <= '0;
                        row_base       <= '0;
                        out_left       <= '0;
                        out_middle     <= '0;
                        out_right      <= '0;
                        out_valid      <= 1'b1;
                        out_result_row <= '0;
                        out_result_col <= '0;
                        state          <= PRESENT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RD_L: begin
                    rd_en   <= 1'b1;
                    rd_addr <= row_base + x_ext;
                    state   <= RD_M;
                end
                RD_M: begin
                    out_left <= (x_cnt != '0) ? rd_data : '0;
                    rd_en    <= !last_strip;
                    rd_addr  <= row_base + x_ext + ONE_ADDR;
                    state    <= RD_R;
                end
                RD_R: begin
                    out_middle <= rd_data;
                    rd_en      <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    out_right        <= last_strip ? '0 : rd_data;
                    out_valid        <= 1'b1;
                    out_result_valid <= res_valid_c;
                    out_result_row   <= res_row_c;
                    out_result_col   <= res_col_c;
                    state            <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid        <= 1'b0;
                        out_result_valid <= 1'b0;
                        if (last_push && last_strip) begin
                            done     <= 1'b1;
                            x_cnt    <= '0;
                            p_cnt    <= '0;
                            row_base <= '0;
                            state    <= IDLE;
                        end else begin
                            x_cnt    <= nxt_x;
                            p_cnt    <= nxt_p;
                            row_base <= nxt_base;
                            if (nxt_is_row) begin
                                rd_en   <= (nxt_x != '0);
                                rd_addr <= nxt_base + nxt_x_ext - ONE_ADDR;
                                state   <= RD_L;
                            end else begin
                                out_left         <= '0;
                                out_middle       <= '0;
                                out_right        <= '0;
                                out_valid        <= 1'b1;
                                out_result_valid <= res_valid_c;
                                out_result_row   <= res_row_c;
                                out_result_col   <= res_col_c;
                                state            <= PRESENT;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_strip_feeder.sv
// Self-checking bench for window_strip_feeder on a 4x3 image with
// pixel(y,x) = 16*y + x + 1. A behavioural model tracks the current strip and
// push, predicts every presented triple, result tag, read sequence and the
// busy/done handshake; directed stimulus covers stalls, ignored starts and a
// mid-frame reset.
module tb_window_strip_feeder;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int IW = 8;
    localparam int AW = 12;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [IW-1:0] rd_data;
    logic [IW-1:0] out_left;
    logic [IW-1:0] out_middle;
    logic [IW-1:0] out_right;
    logic          out_valid;
    logic          out_ready;
    logic          out_result_valid;
    logic [1:0]    out_result_row;
    logic [1:0]    out_result_col;

    logic [IW-1:0] mem [0:W*H-1];

    int checks = 0;
    int errors = 0;

    int m_x = 0;
    int m_p = 0;
    int accepts = 0;
    int reads = 0;
    int rd_q[$];
    int exp_q[$];
    int m_row;
    logic exp_busy = 1'b0;
    logic exp_done = 1'b0;
    logic prev_reset = 1'b1;
    logic stall_prev = 1'b0;
    logic accepted;
    logic is_final;
    logic nb;
    logic nd;
    logic [23:0] held_triple;
    logic [4:0]  held_result;

    window_strip_feeder #(
        .INPUT_WIDTH (IW),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .out_left         (out_left),
        .out_middle       (out_middle),
        .out_right        (out_right),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result_valid (out_result_valid),
        .out_result_row   (out_result_row),
        .out_result_col   (out_result_col)
    );

    function automatic logic [7:0] pix(input int y, input int x);
        return 8'(16 * y + x + 1);
    endfunction

    function automatic logic [23:0] expTriple(input int x, input int p);
        logic [7:0] l;
        logic [7:0] m;
        logic [7:0] r;
        l = 8'd0;
        m = 8'd0;
        r = 8'd0;
        if (p >= 1 && p <= H) begin
            if (x > 0) l = pix(p - 1, x - 1);
            m = pix(p - 1, x);
            if (x < W - 1) r = pix(p - 1, x + 1);
        end
        return {l, m, r};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (x=%0d p=%0d, t=%0t)", name, actual, expected, m_x, m_p, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic rdy, input logic rst, input int cycles);
        start     = s;
        out_ready = rdy;
        reset     = rst;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic waitPush(input int x, input int p);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (out_valid && m_x == x && m_p == p) found = 1'b1;
            else tick();
        end
        checkOutput("reach_push", found, 1);
    endtask

    task automatic waitDone();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (done) found = 1'b1;
        end
        checkOutput("done_seen", found, 1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                mem[y * W + x] = pix(y, x);
    end

    // Pixel memory with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= (int'(rd_addr) < W * H) ? mem[rd_addr] : 8'hEE;
    end

    // Compare the DUT against the model every cycle, then advance the model from this cycle's inputs.
    always @(negedge clk) begin
        if (prev_reset) begin
            checkOutput("reset_rd_en", rd_en, 0);
            checkOutput("reset_rd_addr", rd_addr, 0);
            checkOutput("reset_triple", {out_left, out_middle, out_right}, 0);
            checkOutput("reset_out_valid", out_valid, 0);
            checkOutput("reset_result_valid", out_result_valid, 0);
        end
        checkOutput("busy", busy, exp_busy);
        checkOutput("done", done, exp_done);
        if (!exp_busy) checkOutput("valid_when_idle", out_valid, 0);
        if (stall_prev) begin
            checkOutput("stall_valid_held", out_valid, 1);
            checkOutput("stall_triple_held", {out_left, out_middle, out_right}, held_triple);
            checkOutput("stall_result_held", {out_result_valid, out_result_row, out_result_col}, held_result);
        end
        if (out_valid) begin
            checkOutput("triple", {out_left, out_middle, out_right}, expTriple(m_x, m_p));
            checkOutput("result_valid", out_result_valid, (m_p >= 5));
            if (m_p >= 5) checkOutput("result_pos", {out_result_row, out_result_col}, {2'(m_p - 5), 2'(m_x)});
            checkOutput("read_while_valid", rd_en, 0);
            if (m_x == 0 && m_p == 1) checkOutput("lit_x0_p1", {out_left, out_middle, out_right}, {8'd0, 8'd1, 8'd2});
            if (m_x == 1 && m_p == 2) checkOutput("lit_x1_p2", {out_left, out_middle, out_right}, {8'd17, 8'd18, 8'd19});
            if (m_x == 3 && m_p == 3) checkOutput("lit_x3_p3", {out_left, out_middle, out_right}, {8'd35, 8'd36, 8'd0});
            if (m_x == 2 && m_p == 6) checkOutput("lit_x2_p6_result", {out_result_valid, out_result_row, out_result_col}, {1'b1, 2'd1, 2'd2});
            if (m_x == 2 && m_p == 4) checkOutput("lit_x2_p4_result", out_result_valid, 0);
        end
        if (rd_en) begin
            rd_q.push_back(int'(rd_addr));
            reads++;
        end

        accepted    = out_valid && out_ready;
        stall_prev  = out_valid && !out_ready && !reset;
        held_triple = {out_left, out_middle, out_right};
        held_result = {out_result_valid, out_result_row, out_result_col};

        if (reset) begin
            prev_reset = 1'b1;
            exp_busy   = 1'b0;
            exp_done   = 1'b0;
            stall_prev = 1'b0;
            m_x        = 0;
            m_p        = 0;
            rd_q.delete();
        end else begin
            prev_reset = 1'b0;
            nb = exp_busy;
            nd = 1'b0;
            if (exp_done) begin
                nb = 1'b0;
            end else if (start && !exp_busy) begin
                nb      = 1'b1;
                m_x     = 0;
                m_p     = 0;
                accepts = 0;
                reads   = 0;
                rd_q.delete();
            end
            if (accepted) begin
                accepts++;
                exp_q.delete();
                if (m_p >= 1 && m_p <= H) begin
                    m_row = m_p - 1;
                    if (m_x > 0) exp_q.push_back(m_row * W + m_x - 1);
                    exp_q.push_back(m_row * W + m_x);
                    if (m_x < W - 1) exp_q.push_back(m_row * W + m_x + 1);
                end
                checkOutput("read_count", rd_q.size(), exp_q.size());
                for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++)
                    checkOutput("read_addr", rd_q[i], exp_q[i]);
                rd_q.delete();
                is_final = (m_x == W - 1) && (m_p == H + 4);
                if (is_final) nd = 1'b1;
                if (m_p == H + 4) begin
                    m_p = 0;
                    m_x = (m_x == W - 1) ? 0 : m_x + 1;
                end else begin
                    m_p++;
                end
            end
            exp_busy = nb;
            exp_done = nd;
        end
    end

    // Directed scenario: full frame with a stall and ignored starts, then a mid-frame reset and restart.
    initial begin
        applyStimulus(0, 1, 1, 3);
        applyStimulus(0, 1, 0, 1);

        applyStimulus(1, 1, 0, 1);
        applyStimulus(0, 1, 0, 0);
        waitPush(0, 2);
        applyStimulus(0, 0, 0, 5);
        applyStimulus(0, 1, 0, 0);
        checkOutput("valid_at_ready_return", out_valid, 1);

        waitPush(2, 1);
        applyStimulus(1, 1, 0, 1);
        applyStimulus(0, 1, 0, 0);

        waitDone();
        checkOutput("accepts_frame1", accepts, 32);
        checkOutput("reads_frame1", reads, 30);

        applyStimulus(1, 1, 0, 1);
        applyStimulus(0, 1, 0, 2);
        checkOutput("no_restart_on_done", out_valid, 0);
        checkOutput("busy_after_done", busy, 0);

        applyStimulus(1, 1, 0, 1);
        applyStimulus(0, 1, 0, 0);
        waitPush(1, 3);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("reset_busy_low", busy, 0);
        checkOutput("reset_valid_low", out_valid, 0);
        applyStimulus(0, 1, 0, 3);

        applyStimulus(1, 1, 0, 1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("restart_valid", out_valid, 1);
        checkOutput("restart_triple", {out_left, out_middle, out_right}, 0);
        checkOutput("restart_result_valid", out_result_valid, 0);

        waitDone();
        checkOutput("accepts_frame2", accepts, 32);
        checkOutput("reads_frame2", reads, 30);
        applyStimulus(0, 1, 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
